// File: rtl/mmio_gpio_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : mmio_gpio_bank_if
// Purpose  : Data-space bus between the datapath (DAR/MDR) and the GPIO bank.
// Revision : 1.0
// ============================================================================
interface mmio_gpio_bank_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] addr;
    logic              w_en;
    logic [DATA_W-1:0] d_in;
    logic [DATA_W-1:0] d_out;
    logic              hit;

    modport master (output addr, output w_en, output d_in, input d_out, input hit);
    modport slave  (input addr, input w_en, input d_in, output d_out, output hit);
endinterface
`default_nettype wire

// File: rtl/mmio_gpio_bank.sv
`default_nettype none
// ============================================================================
// Module   : mmio_gpio_bank
// Purpose  : N_PORTS memory-mapped GPIO ports with sync, sticky edges and IRQ.
// Revision : 1.0
// ============================================================================
module mmio_gpio_bank #(
    parameter int                 DATA_W    = 8,
    parameter int                 ADDR_W    = 10,
    parameter int                 N_PORTS   = 4,
    parameter int                 PORT_W    = 4,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = ADDR_W'('h3C0)
) (
    input  wire logic                        clk,
    input  wire logic                        rst_n,
    mmio_gpio_bank_if.slave                  bus,
    input  wire logic [N_PORTS*PORT_W-1:0]   io_in,
    output logic      [N_PORTS*PORT_W-1:0]   io_out,
    output logic      [N_PORTS*PORT_W-1:0]   io_oe,
    output logic                             irq
);
    localparam int                W        = N_PORTS * PORT_W;
    localparam int                PIW      = ADDR_W - 2;
    localparam logic [ADDR_W-1:0] c_IE_OFF = ADDR_W'(4 * N_PORTS);

    logic [W-1:0]       r_s1, r_s2, r_s3;
    logic [W-1:0]       r_out, r_dir, r_edge;
    logic [N_PORTS-1:0] r_ie;
    logic [1:0]         r_cnt;
    logic               r_irq;

    logic [ADDR_W-1:0]  w_off;
    logic               w_hit, w_we, w_is_ie, w_armed;
    logic [PIW-1:0]     w_pidx;
    logic [1:0]         w_reg;
    logic [N_PORTS-1:0] w_out_we, w_dir_we, w_port_any;
    logic [W-1:0]       w_clr, w_rise;
    logic [DATA_W-1:0]  w_rd;
    logic               w_unused_din;

    assign w_off    = bus.addr - BASE_ADDR;
    assign w_hit    = (bus.addr >= BASE_ADDR) && (w_off <= c_IE_OFF);
    assign w_we     = bus.w_en && w_hit;
    assign w_is_ie  = (w_off == c_IE_OFF);
    assign w_pidx   = w_off[ADDR_W-1:2];
    assign w_reg    = w_off[1:0];
    assign w_rise   = r_s2 & ~r_s3;
    // Edges are ignored until the sync pipeline has been refilled after reset.
    assign w_armed  = (r_cnt == 2'd3);
    assign w_unused_din = ^bus.d_in;

    always_comb begin
        w_out_we   = '0;
        w_dir_we   = '0;
        w_clr      = '0;
        w_port_any = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            w_port_any[p] = |r_edge[p*PORT_W +: PORT_W];
            if (w_we && !w_is_ie && (w_pidx == PIW'(p))) begin
                case (w_reg)
                    2'd1:    w_out_we[p] = 1'b1;
                    2'd2:    w_dir_we[p] = 1'b1;
                    2'd3:    w_clr[p*PORT_W +: PORT_W] = bus.d_in[PORT_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_rd = '0;
        if (w_hit) begin
            if (w_is_ie) begin
                w_rd[N_PORTS-1:0] = r_ie;
            end else begin
                for (int p = 0; p < N_PORTS; p++) begin
                    if (w_pidx == PIW'(p)) begin
                        case (w_reg)
                            2'd0:    w_rd[PORT_W-1:0] = r_s2[p*PORT_W +: PORT_W];
                            2'd1:    w_rd[PORT_W-1:0] = r_out[p*PORT_W +: PORT_W];
                            2'd2:    w_rd[PORT_W-1:0] = r_dir[p*PORT_W +: PORT_W];
                            default: w_rd[PORT_W-1:0] = r_edge[p*PORT_W +: PORT_W];
                        endcase
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_s3   <= '0;
            r_out  <= '0;
            r_dir  <= '0;
            r_edge <= '0;
            r_ie   <= '0;
            r_cnt  <= 2'd0;
            r_irq  <= 1'b0;
        end else begin
            r_s1 <= io_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (!w_armed) begin
                r_cnt <= r_cnt + 2'd1;
            end
            for (int p = 0; p < N_PORTS; p++) begin
                if (w_out_we[p]) r_out[p*PORT_W +: PORT_W] <= bus.d_in[PORT_W-1:0];
                if (w_dir_we[p]) r_dir[p*PORT_W +: PORT_W] <= bus.d_in[PORT_W-1:0];
            end
            // A rising edge in the same cycle as its W1C keeps the bit set.
            r_edge <= (r_edge & ~w_clr) | (w_rise & {W{w_armed}});
            if (w_we && w_is_ie) begin
                r_ie <= bus.d_in[N_PORTS-1:0];
            end
            r_irq <= |(r_ie & w_port_any);
        end
    end

    assign bus.d_out = w_rd;
    assign bus.hit   = w_hit;
    assign io_out    = r_out;
    assign io_oe     = r_dir;
    assign irq       = r_irq;
endmodule
`default_nettype wire

// File: doc/mmio_gpio_bank.md
Name: mmio_gpio_bank

Overview:
- Parametrised successor of the fixed 4-bit io_in/io_out pair at two hard-wired addresses.
- Provides N_PORTS independent ports of PORT_W bits, mapped into the data address space.
- Each port has a direction control, a two-flop input synchroniser, sticky rising-edge capture with write-1-to-clear, and a maskable interrupt.
- Sits beside data_mem in the datapath: addressed by dar_out, written from mdr_out, read into the MDR input mux. hit gates the data_mem write enable.

Parameters:
- DATA_W, 8: data bus width.
- ADDR_W, 10: address width (matches DAR).
- N_PORTS, 4: number of ports, 1..DATA_W.
- PORT_W, 4: bits per port, 1..DATA_W.
- BASE_ADDR, 10'h3C0: first address of the register window.

Ports:
- clk, input, 1: clock; all state updates on posedge.
- rst_n, input, 1: reset, synchronous, active-low.
- addr, input, ADDR_W: register address (from DAR).
- w_en, input, 1: write strobe; effective only when hit=1.
- d_in, input, DATA_W: write data (from MDR).
- d_out, output, DATA_W: read data, combinational from addr and state.
- hit, output, 1: addr lies inside the window, combinational.
- io_in, input, N_PORTS*PORT_W: pad inputs, asynchronous; port p occupies bits [p*PORT_W +: PORT_W].
- io_out, output, N_PORTS*PORT_W: output data registers.
- io_oe, output, N_PORTS*PORT_W: per-bit output enable (= DIR).
- irq, output, 1: registered interrupt request.

Behaviour:
- Address map: off = addr - BASE_ADDR. Window is 0 .. 4*N_PORTS (inclusive), so hit = (addr >= BASE_ADDR) && (off <= 4*N_PORTS).
- For port p:
  - off 4p+0 IN: read-only synchronised pad value.
  - off 4p+1 OUT: read/write.
  - off 4p+2 DIR: read/write; 1 = output.
  - off 4p+3 EDGE: sticky rising edges; write 1 to clear.
- off 4*N_PORTS IE: read/write; bit p enables the interrupt for port p; bits at N_PORTS and above read as 0.
- Reads are combinational (same-cycle, like the existing mem_or_io path). Port values are zero-extended to DATA_W; d_out = 0 when hit=0.
- Writes are applied at posedge when w_en && hit.
  - d_in bits above PORT_W (or above N_PORTS for IE) are ignored.
  - Writes to IN are ignored.
  - A write to EDGE clears the bits where d_in=1; other bits are unchanged.
- Synchroniser: s1 <= io_in; s2 <= s1. IN reads s2. IN shows a pad change 2 cycles after it is sampled. IN reflects the pad even on bits configured as outputs.
- Edge detect:
  - s3 <= s2.
  - rise = s2 & ~s3.
  - EDGE <= (EDGE & ~clr) | (rise & armed). Set wins over clear in the same cycle.
- Arming: a 2-bit counter, reset to 0, increments to 3 and holds. armed = (cnt == 3). This suppresses spurious edges while the sync flops fill after reset.
- irq <= |(IE[p] & (|EDGE_p)), registered. It asserts 1 cycle after the EDGE bit is set and deasserts 1 cycle after the clear or the IE write.
- Reset (rst_n=0 at posedge, including mid-operation): s1/s2/s3, OUT, DIR, EDGE, IE, the arming counter and irq all go to 0. io_out = 0, io_oe = 0, irq = 0 the cycle after. Writes in a reset cycle are discarded.
- Address above the window, or below BASE_ADDR: hit=0, no state change, d_out=0.

Test Plan:
- Reset, then read all window offsets: every read 8'h00. io_oe=0, irq=0.
- Write OUT port1 = 8'hFA, DIR port1 = 8'h0F: the next cycle io_out[7:4]=4'hA, io_oe[7:4]=4'hF. Readback of OUT port1 = 8'h0A.
- Hold io_in=16'hFFFF through reset and release: EDGE reads 0 for all ports (arming suppresses). Then drive port0 0->1 on bit2: IN port0 = 8'h04 after 2 cycles; EDGE port0 = 8'h04 one cycle later.
- IE = 8'h01 with EDGE port0 set: irq=1 the next cycle. Write EDGE port0 = 8'h04: EDGE=0, irq=0 one cycle later. Writing 8'h00 clears nothing.
- Rising edge arrives in the same cycle as a W1C of that bit: the bit remains 1.
- Write with addr = BASE_ADDR + 4*N_PORTS + 1 (outside the window), and a write with w_en=0 inside the window: hit as expected (0 and 1 respectively); no register changes in either case.
